// File: rtl/ppu_mmap_if.sv
// PPU-side bus between the PPU address/data master and the memory map.
// Every cycle carries either a read (rw=1) or a write (rw=0); there is no handshake.
interface ppu_mmap_if;
    logic [13:0] addr;
    logic        rw;
    logic [7:0]  data_i;
    logic [7:0]  data_o;

    modport master (
        output addr,
        output rw,
        output data_i,
        input  data_o
    );

    modport slave (
        input  addr,
        input  rw,
        input  data_i,
        output data_o
    );
endinterface

// File: rtl/ppu_mmap.sv
// PPU 14-bit memory map: CHR pattern tables, 2 KB nametable VRAM and 6-bit palette RAM.
// Synchronous writes, one-clock registered read; every address decodes to some location.
module ppu_mmap #(
   parameter bit    MIRROR_VERT  = 1'b1,
   parameter bit    CHR_WRITABLE = 1'b0,
   parameter string CHR_INIT     = "",
   parameter string NT_INIT      = "",
   parameter string PAL_INIT     = ""
) (
   input  logic       clk,
   input  logic       rst,
   ppu_mmap_if.slave  bus
);
   logic [7:0] r_chr  [8192];
   logic [7:0] r_vram [2048];
   logic [5:0] r_pal  [32];
   logic [7:0] r_data_o;

   logic        w_sel_chr;
   logic        w_sel_pal;
   logic        w_page;
   logic [10:0] w_nt_idx;
   logic [4:0]  w_pal_idx;
   logic        w_wr;

   // Load-time contents only; reset never touches the arrays.
   initial begin
      for (int i = 0; i < 8192; i++) r_chr[i]  = 8'h00;
      for (int i = 0; i < 2048; i++) r_vram[i] = 8'h00;
      for (int i = 0; i < 32; i++)   r_pal[i]  = 6'h00;
   end

   assign w_sel_chr = ~bus.addr[13];
   assign w_sel_pal = (bus.addr[13:8] == 6'h3F);
   assign w_page    = MIRROR_VERT ? bus.addr[10] : bus.addr[11];
   assign w_nt_idx  = {w_page, bus.addr[9:0]};
   // Sprite backdrop entries 0x10/14/18/1C fold onto the background ones.
   assign w_pal_idx = {bus.addr[4] & (bus.addr[1:0] != 2'b00), bus.addr[3:0]};
   assign w_wr      = ~rst & ~bus.rw;

   always_ff @(posedge clk) begin
      if (w_wr && w_sel_chr && CHR_WRITABLE) begin
         r_chr[bus.addr[12:0]] <= bus.data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr && !w_sel_chr && !w_sel_pal) begin
         r_vram[w_nt_idx] <= bus.data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr && w_sel_pal) begin
         r_pal[w_pal_idx] <= bus.data_i[5:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data_o <= 8'h00;
      end else if (bus.rw) begin
         if (w_sel_chr) begin
            r_data_o <= r_chr[bus.addr[12:0]];
         end else if (w_sel_pal) begin
            r_data_o <= {2'b00, r_pal[w_pal_idx]};
         end else begin
            r_data_o <= r_vram[w_nt_idx];
         end
      end
   end

   assign bus.data_o = r_data_o;
endmodule

// File: tb/tb_ppu_mmap.sv
// Bench for ppu_mmap: one vertical/CHR-ROM instance and one horizontal/CHR-RAM instance,
// directed scenarios plus random traffic checked against an address-arithmetic model.
module tb_ppu_mmap;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ppu_mmap_if bus_v ();
    ppu_mmap_if bus_h ();

    ppu_mmap #(.MIRROR_VERT(1'b1), .CHR_WRITABLE(1'b0)) dut_v (.clk(clk), .rst(rst), .bus(bus_v.slave));
    ppu_mmap #(.MIRROR_VERT(1'b0), .CHR_WRITABLE(1'b1)) dut_h (.clk(clk), .rst(rst), .bus(bus_h.slave));

    // Model state, index 0 = vertical/ROM instance, 1 = horizontal/RAM instance.
    logic [7:0]  m_chr  [2][8192];
    logic [7:0]  m_vram [2][2048];
    logic [5:0]  m_pal  [2][32];
    logic [7:0]  exp_q  [2];
    logic [13:0] t_addr [2];
    logic        t_rw   [2];
    logic [7:0]  t_d    [2];
    logic        t_rst;
    int total = 0;
    int bad   = 0;

    function automatic int nt_index(int h, int a);
        int off  = (a - 'h2000) % 'h1000;
        int page = (h == 0) ? (off / 'h400) % 2 : (off / 'h800) % 2;
        return page * 1024 + (off % 1024);
    endfunction

    function automatic int pal_index(int a);
        int i = a % 32;
        if (i >= 16 && (i % 4) == 0) i = i - 16;
        return i;
    endfunction

    function automatic logic [7:0] model_rd(int h, int a);
        if (a < 'h2000)       return m_chr[h][a];
        else if (a >= 'h3F00) return {2'b00, m_pal[h][pal_index(a)]};
        else                  return m_vram[h][nt_index(h, a)];
    endfunction

    function automatic void model_wr(int h, int a, logic [7:0] d);
        if (a < 'h2000) begin
            if (h == 1) m_chr[h][a] = d;
        end else if (a >= 'h3F00) begin
            m_pal[h][pal_index(a)] = d[5:0];
        end else begin
            m_vram[h][nt_index(h, a)] = d;
        end
    endfunction

    function automatic logic [7:0] obs(int h);
        return (h == 0) ? bus_v.data_o : bus_h.data_o;
    endfunction

    // One bus clock on both instances; inputs change on the falling edge, model follows the rising edge.
    task automatic cycle();
        @(negedge clk);
        rst = t_rst;
        bus_v.addr = t_addr[0]; bus_v.rw = t_rw[0]; bus_v.data_i = t_d[0];
        bus_h.addr = t_addr[1]; bus_h.rw = t_rw[1]; bus_h.data_i = t_d[1];
        @(posedge clk);
        for (int h = 0; h < 2; h++) begin
            if (t_rst)          exp_q[h] = 8'h00;
            else if (t_rw[h])   exp_q[h] = model_rd(h, int'(t_addr[h]));
            else                model_wr(h, int'(t_addr[h]), t_d[h]);
        end
        #1;
    endtask

    task automatic op(int h, logic rw, logic [13:0] a, logic [7:0] d);
        t_addr[h] = a; t_rw[h] = rw; t_d[h] = d;
        t_rw[1 - h] = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        for (int h = 0; h < 2; h++) begin t_addr[h] = 14'h2000; t_rw[h] = 1'b1; t_d[h] = 8'h00; end
        t_rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            cycle();
            for (int h = 0; h < 2; h++) begin
                total++;
                if (obs(h) !== 8'h00) begin
                    bad++; $display("FAIL reset_data_o inst%0d: got %h want 00", h, obs(h));
                end
            end
        end
        t_rst = 1'b0;
        cycle();
        for (int h = 0; h < 2; h++) begin
            total++;
            if (obs(h) !== m_vram[h][0]) begin
                bad++; $display("FAIL reset_release_read inst%0d: got %h want %h", h, obs(h), m_vram[h][0]);
            end
        end
    endtask

    task automatic test_vert_mirror();
        logic [13:0] ra [4] = '{14'h2800, 14'h3000, 14'h2C00, 14'h2000};
        logic [7:0]  rv [4] = '{8'hA5, 8'hA5, 8'h5A, 8'hA5};
        op(0, 1'b0, 14'h2000, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) op(0, 1'b0, 14'h2400, 8'h5A);
            op(0, 1'b1, ra[i], 8'h00);
            total++;
            if (obs(0) !== rv[i]) begin
                bad++; $display("FAIL vert_mirror @%h: got %h want %h", ra[i], obs(0), rv[i]);
            end
        end
    endtask

    task automatic test_horiz_mirror();
        logic [13:0] ra [3] = '{14'h2400, 14'h2C00, 14'h2000};
        logic [7:0]  rv [3] = '{8'h11, 8'h22, 8'h11};
        op(1, 1'b0, 14'h2000, 8'h11);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) op(1, 1'b0, 14'h2800, 8'h22);
            op(1, 1'b1, ra[i], 8'h00);
            total++;
            if (obs(1) !== rv[i]) begin
                bad++; $display("FAIL horiz_mirror @%h: got %h want %h", ra[i], obs(1), rv[i]);
            end
        end
    endtask

    task automatic test_palette();
        logic [13:0] wa [4] = '{14'h3F10, 14'h3F01, 14'h3F11, 14'h3F11};
        logic [7:0]  wd [4] = '{8'h0F, 8'hFF, 8'h30, 8'h30};
        logic [13:0] ra [4] = '{14'h3F00, 14'h3F21, 14'h3F01, 14'h3F11};
        logic [7:0]  rv [4] = '{8'h0F, 8'h3F, 8'h3F, 8'h30};
        for (int i = 0; i < 4; i++) begin
            if (i != 3) op(0, 1'b0, wa[i], wd[i]);
            op(0, 1'b1, ra[i], 8'h00);
            total++;
            if (obs(0) !== rv[i]) begin
                bad++; $display("FAIL palette @%h: got %h want %h", ra[i], obs(0), rv[i]);
            end
        end
    endtask

    task automatic test_chr();
        logic [7:0] want;
        for (int h = 0; h < 2; h++) begin
            want = (h == 0) ? 8'h00 : 8'h99;
            op(h, 1'b0, 14'h0010, 8'h99);
            op(h, 1'b1, 14'h0010, 8'h00);
            total++;
            if (obs(h) !== want) begin
                bad++; $display("FAIL chr_write inst%0d: got %h want %h", h, obs(h), want);
            end
        end
    endtask

    task automatic test_hold();
        op(0, 1'b0, 14'h2001, 8'h3C);
        op(0, 1'b1, 14'h2001, 8'h00);
        op(0, 1'b0, 14'h2002, 8'h77);
        total++;
        if (obs(0) !== 8'h3C) begin
            bad++; $display("FAIL hold_during_write: got %h want 3c", obs(0));
        end
        op(0, 1'b1, 14'h2002, 8'h00);
        total++;
        if (obs(0) !== 8'h77) begin
            bad++; $display("FAIL write_then_read: got %h want 77", obs(0));
        end
    endtask

    task automatic test_reset_mid();
        op(1, 1'b0, 14'h2003, 8'h5C);
        op(1, 1'b1, 14'h2003, 8'h00);
        t_rst = 1'b1;
        op(1, 1'b0, 14'h2003, 8'h44);
        total++;
        if (obs(1) !== 8'h00) begin
            bad++; $display("FAIL reset_mid_data_o: got %h want 00", obs(1));
        end
        t_rst = 1'b0;
        op(1, 1'b1, 14'h2003, 8'h00);
        total++;
        if (obs(1) !== 8'h5C) begin
            bad++; $display("FAIL reset_mid_write_dropped: got %h want 5c", obs(1));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            for (int h = 0; h < 2; h++) begin
                case ($urandom_range(0, 3))
                    0:       t_addr[h] = 14'($urandom_range(0, 'h1FFF));
                    1:       t_addr[h] = 14'($urandom_range('h3F00, 'h3FFF));
                    default: t_addr[h] = 14'($urandom_range('h2000, 'h3EFF));
                endcase
                t_rw[h] = ($urandom_range(0, 2) != 0);
                t_d[h]  = 8'($urandom);
            end
            cycle();
            for (int h = 0; h < 2; h++) begin
                total++;
                if (obs(h) !== exp_q[h]) begin
                    bad++;
                    $display("FAIL random inst%0d @%h rw=%0d: got %h want %h", h, t_addr[h], t_rw[h], obs(h), exp_q[h]);
                end
            end
        end
    endtask

    initial begin
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < 8192; i++) m_chr[h][i] = 8'h00;
            for (int i = 0; i < 2048; i++) m_vram[h][i] = 8'h00;
            for (int i = 0; i < 32; i++)   m_pal[h][i] = 6'h00;
            exp_q[h] = 8'h00; t_addr[h] = 14'h2000; t_rw[h] = 1'b1; t_d[h] = 8'h00;
        end
        t_rst = 1'b1;
        test_reset();
        test_vert_mirror();
        test_horiz_mirror();
        test_palette();
        test_chr();
        test_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
